// File: rtl/memory_pkg.sv
// Shared sizing and types for the 2x4 memory controller and its cell arbiter.
// Pure declarations, no latency or flow control.
package memory_pkg;
    localparam int USERS     = 4;
    localparam int CELLS     = 2;
    localparam int USER_BITS = 2;

    typedef logic [USER_BITS-1:0] userIndex_t;
    typedef logic [CELLS-1:0]     cellMask_t;
    typedef logic [USERS-1:0]     userMask_t;

    function automatic userMask_t userOneHot(input userIndex_t u);
        return userMask_t'(1) << u;
    endfunction
endpackage

// File: rtl/memory_cell_arbiter_if.sv
// User-side request/grant/release bundle of the cell arbiter.
// Level requests, one-cycle release and grant pulses.
interface memory_cell_arbiter_if;
    import memory_pkg::*;

    userMask_t  request;
    userMask_t  requestPair;
    userMask_t  releaseReq;
    userMask_t  grant;
    cellMask_t  grantCell;
    userIndex_t cell0ToUser;
    userIndex_t cell1ToUser;
    cellMask_t  cellBusy;

    modport master (
        output request, requestPair, releaseReq,
        input  grant, grantCell, cell0ToUser, cell1ToUser, cellBusy
    );

    modport slave (
        input  request, requestPair, releaseReq,
        output grant, grantCell, cell0ToUser, cell1ToUser, cellBusy
    );
endinterface

// File: rtl/memory_cell_arbiter_rr_picker.sv
// Round-robin first-one finder over four users, starting at user rr.
// Combinational, no backpressure.
module rr_picker
    import memory_pkg::*;
(
    input  userMask_t  eligible,
    input  userIndex_t rr,
    output userIndex_t index,
    output logic       valid
);
    userIndex_t cand;

    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest eligible user wins.
        for (int i = USERS - 1; i >= 0; i--) begin
            cand = rr + userIndex_t'(i);
            if (eligible[cand]) begin
                index = cand;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/memory_cell_arbiter.sv
// Allocates the two RAM cells to four users, single or paired ownership.
// Grant one cycle after request edge; requests wait (level) until granted.
module memory_cell_arbiter
    import memory_pkg::*;
#(
    parameter int users = USERS,
    parameter int cells = CELLS
) (
    input logic                  clk,
    input logic                  resetN,
    memory_cell_arbiter_if.slave bus
);
    logic [cells-1:0] busyQ;
    userIndex_t       owner0Q, owner1Q, rrQ;
    userMask_t        grantQ;
    cellMask_t        grantCellQ;

    logic [users-1:0] ownsAny, eligible, pairWant, secondEligible;
    cellMask_t        relMask;
    userIndex_t       firstIdx, secondIdx;
    logic             firstVld, secondVld;

    always_comb begin
        ownsAny = '0;
        for (int u = 0; u < users; u++) begin
            ownsAny[u] = (busyQ[0] && owner0Q == userIndex_t'(u)) ||
                         (busyQ[1] && owner1Q == userIndex_t'(u));
        end
    end

    assign eligible = (bus.request | bus.requestPair) & ~ownsAny;
    assign pairWant = bus.requestPair & ~ownsAny;
    // After a single grant no pair can fit, so only singles compete for the second cell.
    assign secondEligible = eligible & ~pairWant & ~userOneHot(firstIdx);
    assign relMask = {busyQ[1] && bus.releaseReq[owner1Q],
                      busyQ[0] && bus.releaseReq[owner0Q]};

    rr_picker u_first  (.eligible(eligible),       .rr(rrQ), .index(firstIdx),  .valid(firstVld));
    rr_picker u_second (.eligible(secondEligible), .rr(rrQ), .index(secondIdx), .valid(secondVld));

    userMask_t  grantNext;
    cellMask_t  grantCellNext, assignCell;
    userIndex_t newOwner0, newOwner1, rrNext;

    always_comb begin
        grantNext     = '0;
        grantCellNext = '0;
        assignCell    = '0;
        newOwner0     = owner0Q;
        newOwner1     = owner1Q;
        rrNext        = rrQ;
        if (firstVld) begin
            if (pairWant[firstIdx]) begin
                // A blocked pair requester at the head stalls everyone to drain cells.
                if (busyQ == 2'b00) begin
                    grantNext     = userOneHot(firstIdx);
                    grantCellNext = 2'b11;
                    assignCell    = 2'b11;
                    newOwner0     = firstIdx;
                    newOwner1     = firstIdx;
                    rrNext        = firstIdx + 2'd1;
                end
            end else if (!busyQ[0]) begin
                assignCell[0] = 1'b1;
                newOwner0     = firstIdx;
                if (!busyQ[1] && secondVld) begin
                    grantNext     = userOneHot(firstIdx) | userOneHot(secondIdx);
                    assignCell[1] = 1'b1;
                    newOwner1     = secondIdx;
                    rrNext        = secondIdx + 2'd1;
                end else begin
                    grantNext     = userOneHot(firstIdx);
                    grantCellNext = 2'b01;
                    rrNext        = firstIdx + 2'd1;
                end
            end else if (!busyQ[1]) begin
                grantNext     = userOneHot(firstIdx);
                grantCellNext = 2'b10;
                assignCell[1] = 1'b1;
                newOwner1     = firstIdx;
                rrNext        = firstIdx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busyQ      <= '0;
            owner0Q    <= '0;
            owner1Q    <= '0;
            rrQ        <= '0;
            grantQ     <= '0;
            grantCellQ <= '0;
        end else begin
            busyQ      <= (busyQ & ~relMask) | assignCell;
            owner0Q    <= newOwner0;
            owner1Q    <= newOwner1;
            rrQ        <= rrNext;
            grantQ     <= grantNext;
            grantCellQ <= grantCellNext;
        end
    end

    assign bus.grant       = grantQ;
    assign bus.grantCell   = grantCellQ;
    assign bus.cellBusy    = busyQ;
    assign bus.cell0ToUser = owner0Q;
    assign bus.cell1ToUser = owner1Q;
endmodule

// File: doc/memory_cell_arbiter.md
# memory_cell_arbiter

Allocates the two RAM cells of the 2x4 memory controller to its four users. Runs a per-user request/grant/release handshake and drives the controller's `cell0ToUser`/`cell1ToUser` routing selects. Supports single-cell ownership and paired ownership, where one user holds both cells so a single write lands in both. Sits beside `MemoryController2x4`, on the same clock, as the sole source of its cell-to-user mapping.

## Interface
Parameters:
- `users`, 4, number of users; fixed at 4 (2-bit user index).
- `cells`, 2, number of cells; fixed at 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetN`  in  1  reset, asynchronous, active-low.
- `request`  in  4  per-user level request for one cell; held until granted.
- `requestPair`  in  4  per-user level request for both cells; wins over `request` from the same user.
- `release`  in  4  per-user one-cycle pulse; frees every cell that user owns.
- `grant`  out  4  per-user one-cycle pulse; the user now owns the indicated cell(s).
- `grantCell`  out  2  bitmask of cells granted to the user in the current `grant` pulse; valid only while exactly one `grant` bit is set, else 0.
- `cell0ToUser`  out  2  owner index of cell 0, to controller.
- `cell1ToUser`  out  2  owner index of cell 1, to controller.
- `cellBusy`  out  2  bit c set while cell c is owned.

## Operation
- Per-cell state: a busy flag and a 2-bit owner. Round-robin pointer `rr` (2 bits) gives highest priority to user `rr`, then `rr+1`, and so on, mod 4.
- **Eligible users.** A user is eligible when `request` or `requestPair` is high and it owns no cell at the sampling edge. All inputs from owning users are ignored, except `release`.
- **Release.** `release[u]` clears busy on every cell whose owner is u. Releases from non-owners are ignored.
- **Grant computation.** Grants are computed from the busy flags before that edge's releases, so a released cell is grantable from the next edge.
- **Grant scan.** Eligible users are walked in priority order.
  - A pair requester is granted only when both cells are free. It then takes both cells, and the scan ends.
  - A single requester takes the lowest-numbered free cell.
  - At most two grants per edge.
- **Starvation guard.** If the first eligible user in priority order is a pair requester and both cells are not free, no grants are issued that edge. This drains cells for it.
- **Pointer update.** If any grant issued, `rr` = (last granted user in scan order) + 1 mod 4. Otherwise `rr` is unchanged.
- **Owner selects.** A cell's `cellNToUser` changes only on grant to that cell. It holds the last owner while the cell is free.
- **`grantCell` with two grants.** When two users are granted on the same edge, `grantCell` is 0. Each of those users reads its cell from `cell0ToUser`/`cell1ToUser`.

## Timing
- **Reset values** (while `resetN` low, asynchronously): `grant`=0, `grantCell`=0, `cellBusy`=0, `cell0ToUser`=0, `cell1ToUser`=0, `rr`=0.
- **Reset mid-operation:** all ownership is dropped immediately. Users must treat reset as implicit release.
- **Registered outputs:** all outputs are registered; none are combinational from inputs.
- **Request-to-grant latency.** If eligible request(s) are present at edge k and won, then after edge k:
  - `grant` pulses for exactly one cycle;
  - `cellBusy` and `cellNToUser` update;
  - the controller routes the new owner from edge k+1.
- **Release latency:** `release` at edge k clears `cellBusy` after edge k; the cell can be granted at edge k+1 at the earliest.
- **Request deassertion:** a user must deassert `request`/`requestPair` on the cycle `grant` is seen. A request still high at edge k+1 is ignored because the user owns a cell.
- **Same-user release plus request at one edge:** the release is processed. The request is ignored because the user is an owner at sampling; it is re-evaluated at k+1.
- **Different users:** release by one user and request by another at the same edge follow the rule above; the freed cell goes at k+1.

## Structure
- **Package `memory_pkg`:** `USERS`=4, `CELLS`=2, `USER_BITS`=2, `userIndex_t`, `cellMask_t`. Shared with the memory controller.
- **Sub-module `rr_picker`:** 4-input round-robin first-one finder. It takes `eligible[3:0]` and `rr` and returns index plus valid. It is instantiated twice, with the second copy masking the first winner.
- **Main module:** everything else (pair logic, busy/owner registers, pointer) lives in `memory_cell_arbiter`.

## Test plan
- **Reset:** hold `resetN` low mid-grant → all outputs 0 asynchronously; after release, `request`=0001 → `grant`=0001, `grantCell`=01, `cell0ToUser`=0, `cellBusy`=01.
- **Double single grant:** `request`=0110 at one edge, `rr`=0 → both granted same edge. Required: `grant`=0110, `grantCell`=00, `cell0ToUser`=1, `cell1ToUser`=2, `cellBusy`=11, `rr`=3.
- **Pair grant:** both free, `requestPair`=1000 → `grant`=1000, `grantCell`=11, both selects=3, `cellBusy`=11. A write by user 3 at address 1 of 16'hC0FE appears in both cells' RAM.
- **Starvation guard:** user 0 owns cell 0, `rr`=2, `requestPair`=0100, `request`=0010 → no grant while cell 0 busy. User 0 releases at edge k → user 2 gets pair grant at edge k+1; user 1 waits.
- **Release timing and round robin:** all four request singly, with owners releasing one cycle after each grant → grants rotate 0,1 then 2,3 then 0,1. No released cell is granted on its release edge. `release` from a non-owner leaves `cellBusy` unchanged.
- **Illegal/ignored inputs:** owner holds `request` high after grant → no second grant. `request` and `requestPair` from the same user → treated as a pair request.
